// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor:
// register offsets, bus FSM states and strobe merging.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  typedef enum logic {
    IDLE,
    RESP
  } clint_state_t;

  function automatic logic [63:0] strb_merge(
    input logic [63:0] old_v,
    input logic [63:0] wdata,
    input logic [7:0]  strb
  );
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Prescaled mtime counter with a byte-strobed write
// port and the registered mtime >= mtimecmp comparator.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [7:0]  strb_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] mtimecmp_d_i,
  output logic [63:0] mtime_o,
  output logic        trint_o
);

  localparam int unsigned PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          trint_q;
  logic          tick;

  assign tick = (presc_q == PMAX);

  // A store wins over a tick; the prescaler keeps running.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = mtime_q;
    if (we_i) begin
      mtime_d = strb_merge(mtime_q, wdata_i, strb_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
      trint_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      trint_q <= (mtime_d >= mtimecmp_d_i);
    end
  end

  assign mtime_o = mtime_q;
  assign trint_o = trint_q;

endmodule

// File: rtl/clint.sv
// CLINT bus responder: two-state request FSM, msip and
// mtimecmp registers, timer sub-block and interrupt lines.
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [63:0] resp_data,
  output logic        trint,
  output logic        swint
);

  clint_state_t state_q;

  logic        msip_q, msip_d;
  logic        swint_q;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] resp_q, resp_d;
  logic [63:0] mtime;
  logic [63:0] rdata;
  logic [63:0] off;
  logic        in_win;
  logic        sel_msip, sel_cmp, sel_mtime;
  logic        accept, wr;
  logic        unused_off;

  assign off        = req_addr - BASE;
  assign unused_off = ^off[2:0];
  assign in_win     = (off[63:16] == '0);

  assign sel_msip  = in_win &&
    (off[15:3] == CLINT_MSIP[15:3]);
  assign sel_cmp   = in_win &&
    (off[15:3] == CLINT_MTIMECMP[15:3]);
  assign sel_mtime = in_win &&
    (off[15:3] == CLINT_MTIME[15:3]);

  assign accept = reset && req_valid &&
    (state_q == IDLE);
  assign wr     = accept && req_write;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_msip:  rdata = {63'b0, msip_q};
      sel_cmp:   rdata = mtimecmp_q;
      sel_mtime: rdata = mtime;
      default:   rdata = '0;
    endcase
  end

  // Stores commit on the accepting edge; loads see pre-store state.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    resp_d     = resp_q;
    if (wr && sel_msip && req_strobe[0]) begin
      msip_d = req_data[0];
    end
    if (wr && sel_cmp) begin
      mtimecmp_d = strb_merge(mtimecmp_q, req_data,
                              req_strobe);
    end
    if (accept) begin
      resp_d = req_write ? '0 : rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      msip_q     <= 1'b0;
      swint_q    <= 1'b0;
      mtimecmp_q <= '1;
      resp_q     <= '0;
    end else begin
      msip_q     <= msip_d;
      swint_q    <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      resp_q     <= resp_d;
      unique case (state_q)
        IDLE:    if (accept) state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk          (clk),
    .rst_n        (reset),
    .we_i         (wr && sel_mtime),
    .strb_i       (req_strobe),
    .wdata_i      (req_data),
    .mtimecmp_d_i (mtimecmp_d),
    .mtime_o      (mtime),
    .trint_o      (trint)
  );

  // Gating by reset drops a response caught mid-flight.
  assign addr_ok   = accept;
  assign data_ok   = reset && (state_q == RESP);
  assign resp_data = data_ok ? resp_q : '0;
  assign swint     = swint_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: TICK_DIV=1 and TICK_DIV=4 instances
// share one bus; a scoreboard checks every response.
module tb_clint;

  localparam logic [63:0] B   = 64'h0200_0000;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [7:0]  req_strobe = '0;
  logic [63:0] req_data = '0;

  logic        addr_ok1, data_ok1, trint1, swint1;
  logic [63:0] resp1;
  logic        addr_ok4, data_ok4, trint4, swint4;
  logic [63:0] resp4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clint #(.BASE(B), .TICK_DIV(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_strobe (req_strobe),
    .req_data   (req_data),
    .addr_ok    (addr_ok1),
    .data_ok    (data_ok1),
    .resp_data  (resp1),
    .trint      (trint1),
    .swint      (swint1)
  );

  clint #(.BASE(B), .TICK_DIV(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_strobe (req_strobe),
    .req_data   (req_data),
    .addr_ok    (addr_ok4),
    .data_ok    (data_ok4),
    .resp_data  (resp4),
    .trint      (trint4),
    .swint      (swint4)
  );

  typedef struct {
    string       name;
    logic [63:0] lo1, hi1, lo4, hi4;
  } exp_t;

  typedef struct {
    string       name;
    logic        w;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vq[$];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] lo,
                     input logic [63:0] hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %h want %h..%h", n, act, lo, hi);
    end
  endtask

  task automatic push(input string n,
                      input logic [63:0] lo1, hi1, lo4, hi4);
    exp_t e;
    e.name = n;
    e.lo1 = lo1; e.hi1 = hi1;
    e.lo4 = lo4; e.hi4 = hi4;
    sb.push_back(e);
  endtask

  task automatic addv(input string n, input logic w,
                      input logic [63:0] a,
                      input logic [7:0] s,
                      input logic [63:0] d,
                      input logic [63:0] x);
    vec_t v;
    v.name = n; v.w = w; v.addr = a;
    v.strb = s; v.data = d; v.exp = x;
    vq.push_back(v);
  endtask

  always @(negedge clk) begin
    if (data_ok1 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_1"}, resp1, e.lo1, e.hi1);
        chk({e.name, "_4"}, resp4, e.lo4, e.hi4);
        chk({e.name, "_dok4"}, data_ok4, 64'd1, 64'd1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic w, input logic [63:0] a,
                      input logic [7:0] s,
                      input logic [63:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a;
    req_strobe = s; req_data = d;
    #1;
    chk("addr_ok", addr_ok1, 64'd1, 64'd1);
    chk("addr_ok4", addr_ok4, 64'd1, 64'd1);
    @(posedge clk);
    #1;
    chk("addr_ok_resp", addr_ok1, 64'd0, 64'd0);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    req_strobe = '0; req_data = '0;
    chk("data_ok", data_ok1, 64'd1, 64'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    chk("data_ok_one", data_ok1, 64'd0, 64'd0);
  endtask

  task automatic xact(input string n, input logic w,
                      input logic [63:0] a,
                      input logic [7:0] s,
                      input logic [63:0] d,
                      input logic [63:0] lo1, hi1, lo4, hi4);
    push(n, lo1, hi1, lo4, hi4);
    send(w, a, s, d);
    drain();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    addv("cmp_rst", 0, B+64'h4000, 8'h00, 0, ALL);
    addv("cmp_wr", 1, B+64'h4000, 8'hFF,
         64'h0123_4567_89AB_CDEF, 0);
    addv("cmp_rd", 0, B+64'h4000, 8'h00, 0,
         64'h0123_4567_89AB_CDEF);
    addv("cmp_hi", 1, B+64'h4000, 8'hF0, ALL, 0);
    addv("cmp_rdh", 0, B+64'h4000, 8'h00, 0,
         64'hFFFF_FFFF_89AB_CDEF);
    addv("cmp_b02", 1, B+64'h4000, 8'h05,
         64'h0000_0000_0011_0022, 0);
    addv("cmp_rdb", 0, B+64'h4000, 8'h00, 0,
         64'hFFFF_FFFF_8911_CD22);
    addv("cmp_lsb", 0, B+64'h4004, 8'h00, 0,
         64'hFFFF_FFFF_8911_CD22);
    addv("oow_rd", 0, 64'h0300_4000, 8'h00, 0, 0);
    addv("unm_wr", 1, B+64'h1000, 8'hFF, ALL, 0);
    addv("unm_rd", 0, B+64'h1000, 8'h00, 0, 0);
    addv("msip_nb0", 1, B, 8'h02, ALL, 0);
    addv("msip_rd0", 0, B, 8'h00, 0, 0);
    addv("msip_b0", 1, B, 8'h01, 64'h3, 0);
    addv("msip_rd1", 0, B, 8'h00, 0, 1);
    addv("msip_clr", 1, B, 8'hFF, 0, 0);

    // reset state and a first mtime load
    do_reset();
    chk("rst_trint", trint1, 0, 0);
    chk("rst_swint", swint1, 0, 0);
    chk("rst_dok", data_ok1, 0, 0);
    chk("rst_resp", resp1, 0, 0);
    chk("rst_trint4", trint4, 0, 0);
    repeat (5) @(negedge clk);
    xact("mtime5", 0, B+64'hBFF8, 0, 0, 5, 6, 1, 2);

    for (int i = 0; i < vq.size(); i++) begin
      xact(vq[i].name, vq[i].w, vq[i].addr, vq[i].strb,
           vq[i].data, vq[i].exp, vq[i].exp,
           vq[i].exp, vq[i].exp);
    end

    // timer interrupt rise and fall
    do_reset();
    xact("cmp20", 1, B+64'h4000, 8'hFF, 64'd20, 0, 0, 0, 0);
    n = 0;
    while (trint1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("trint_wait", (n < 100) ? 64'd1 : 64'd0, 1, 1);
    xact("mtime_at_trint", 0, B+64'hBFF8, 0, 0,
         20, 20, 0, ALL);
    push("cmp1000", 0, 0, 0, 0);
    send(1, B+64'h4000, 8'hFF, 64'd1000);
    chk("trint_fall", trint1, 0, 0);
    drain();

    // software interrupt
    push("msip_set", 0, 0, 0, 0);
    send(1, B, 8'h0F, 64'hFFFF_FFFF);
    chk("swint_set", swint1, 1, 1);
    chk("swint_set4", swint4, 1, 1);
    drain();
    xact("msip_rd", 0, B, 0, 0, 1, 1, 1, 1);
    push("msip_zero", 0, 0, 0, 0);
    send(1, B, 8'hFF, 64'd0);
    chk("swint_clr", swint1, 0, 0);
    drain();

    // mtime wrap and store-over-tick
    xact("mt_wr", 1, B+64'hBFF8, 8'hFF,
         64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0);
    xact("mt_max", 0, B+64'hBFF8, 0, 0, ALL, ALL, 0, ALL);
    xact("mt_wrap", 0, B+64'hBFF8, 0, 0, 1, 1, 0, ALL);
    xact("mt_ab", 1, B+64'hBFF8, 8'h01,
         64'h5555_5555_5555_55AB, 0, 0, 0, 0);
    xact("mt_ab_rd", 0, B+64'hBFF8, 0, 0,
         64'hAC, 64'hAC, 0, ALL);

    // prescaler
    do_reset();
    repeat (40) @(negedge clk);
    xact("mt40", 0, B+64'hBFF8, 0, 0, 39, 41, 9, 11);
    xact("unm1000", 0, B+64'h1000, 0, 0, 0, 0, 0, 0);

    // reset while a response is pending
    xact("pre_msip", 1, B, 8'h01, 64'd1, 0, 0, 0, 0);
    xact("pre_cmp", 1, B+64'h4000, 8'hFF, 0, 0, 0, 0, 0);
    chk("pre_trint", trint1, 1, 1);
    chk("pre_swint", swint1, 1, 1);
    req_valid = 1'b1; req_write = 1'b0;
    req_addr = B+64'h4000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rr_dok", data_ok1, 0, 0);
    chk("rr_dok4", data_ok4, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    chk("rr_trint", trint1, 0, 0);
    chk("rr_swint", swint1, 0, 0);
    chk("rr_trint4", trint4, 0, 0);
    chk("rr_swint4", swint4, 0, 0);
    xact("rr_msip", 0, B, 0, 0, 0, 0, 0, 0);
    xact("rr_cmp", 0, B+64'h4000, 0, 0, ALL, ALL, ALL, ALL);
    xact("rr_mtime", 0, B+64'hBFF8, 0, 0, 4, 4, 1, 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
